// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with 3-sample majority RX and valid/ready TX.
// Optional break detection (rx_break port, BREAK state) enabled by `define UART_BREAK_DETECT_EN.
`default_nettype none

module uart_param #(
  parameter int CLK_DIV    = 81,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy,
  output logic                 tx_busy
`ifdef UART_BREAK_DETECT_EN
  , output logic               rx_break
`endif
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_MAX   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] S_FIRST = TW'(H - 2);
  localparam logic [TW-1:0] S_MID   = TW'(H - 1);
  localparam logic [TW-1:0] S_LAST  = TW'(H);
  localparam logic [BW-1:0] B_MAX   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
`ifdef UART_BREAK_DETECT_EN
    , RX_BREAK
`endif
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // ---------------- RX ----------------
  logic rx_meta, rxs;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  rx_state_t rx_state, rx_next;
  logic [PW-1:0]        rx_pre;
  logic [TW-1:0]        rx_tcnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic s0, s1, samp, bit_val, par_bit;
  logic rx_tick, rx_bit_end, rx_start, emit, brk_hold;

  assign rx_tick    = (rx_pre == PRE_MAX);
  assign rx_bit_end = rx_tick && (rx_tcnt == T_MAX);
  assign rx_start   = (rx_state == RX_IDLE) && !rxs;
  assign emit       = (rx_state == RX_STOP) && samp;
  assign rx_busy    = (rx_state != RX_IDLE);

`ifdef UART_BREAK_DETECT_EN
  logic frame_zero;
  assign frame_zero = (rx_shift == '0) && ((PARITY == 0) || !par_bit) && !bit_val;
  assign brk_hold   = (rx_state == RX_BREAK) && !rxs;
`else
  assign brk_hold   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rxs) rx_next = RX_START;
      RX_START:  if (samp && bit_val) rx_next = RX_IDLE;
                 else if (rx_bit_end) rx_next = RX_DATA;
      RX_DATA:   if (rx_bit_end && rx_bit == B_MAX)
                   rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
`ifdef UART_BREAK_DETECT_EN
      RX_STOP:   if (samp) rx_next = frame_zero ? RX_BREAK : RX_IDLE;
      RX_BREAK:  if (rx_tick && rxs && rx_tcnt == TW'(H - 1)) rx_next = RX_IDLE;
`else
      RX_STOP:   if (samp) rx_next = RX_IDLE;
`endif
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_pre        <= '0;
      rx_tcnt       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      s0            <= 1'b0;
      s1            <= 1'b0;
      samp          <= 1'b0;
      bit_val       <= 1'b0;
      par_bit       <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      rx_break      <= 1'b0;
`endif
    end else begin
      samp     <= 1'b0;
      rx_valid <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      rx_break <= 1'b0;
`endif
      if (rx_start) begin
        rx_pre  <= '0;
        rx_tcnt <= '0;
        rx_bit  <= '0;
      end else begin
        rx_pre <= rx_tick ? '0 : rx_pre + 1'b1;
        if (brk_hold)     rx_tcnt <= '0;
        else if (rx_tick) rx_tcnt <= (rx_tcnt == T_MAX) ? '0 : rx_tcnt + 1'b1;
        // Three samples straddle the bit centre; the vote is consumed one cycle later.
        if (rx_tick && rx_state != RX_IDLE) begin
          if (rx_tcnt == S_FIRST) s0 <= rxs;
          if (rx_tcnt == S_MID)   s1 <= rxs;
          if (rx_tcnt == S_LAST) begin
            bit_val <= (s0 & s1) | (s0 & rxs) | (s1 & rxs);
            samp    <= 1'b1;
          end
        end
        if (rx_bit_end && rx_state == RX_DATA) rx_bit <= rx_bit + 1'b1;
        if (samp && rx_state == RX_DATA)   rx_shift <= {bit_val, rx_shift[DATA_BITS-1:1]};
        if (samp && rx_state == RX_PARITY) par_bit  <= bit_val;
        if (emit) begin
          rx_valid      <= 1'b1;
          rx_data       <= rx_shift;
          rx_frame_err  <= !bit_val;
          rx_parity_err <= (PARITY != 0) && ((^rx_shift ^ par_bit) != (PARITY == 2));
          rx_tcnt       <= '0;
`ifdef UART_BREAK_DETECT_EN
          rx_break      <= frame_zero;
`endif
        end
      end
    end
  end

  // ---------------- TX ----------------
  tx_state_t tx_state, tx_next;
  logic [PW-1:0]        tx_pre;
  logic [TW-1:0]        tx_tcnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic tx_par, tx_stop2, tx_tick, tx_bit_end, accept;

  assign tx_tick    = (tx_pre == PRE_MAX);
  assign tx_bit_end = tx_tick && (tx_tcnt == T_MAX);
  assign accept     = tx_valid && (tx_state == TX_IDLE);
  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_busy    = !tx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx      = 1'b1;
    case (tx_state)
      TX_IDLE:   if (tx_valid) tx_next = TX_START;
      TX_START:  begin
                   tx = 1'b0;
                   if (tx_bit_end) tx_next = TX_DATA;
                 end
      TX_DATA:   begin
                   tx = tx_shift[0];
                   if (tx_bit_end && tx_bit == B_MAX)
                     tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
                 end
      TX_PARITY: begin
                   tx = tx_par;
                   if (tx_bit_end) tx_next = TX_STOP;
                 end
      TX_STOP:   if (tx_bit_end && (STOP_BITS == 1 || tx_stop2)) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_pre   <= '0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_stop2 <= 1'b0;
    end else if (accept) begin
      tx_pre   <= '0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_stop2 <= 1'b0;
      tx_shift <= tx_data;
      tx_par   <= ^tx_data ^ (PARITY == 2);
    end else begin
      tx_pre <= tx_tick ? '0 : tx_pre + 1'b1;
      if (tx_tick) tx_tcnt <= (tx_tcnt == T_MAX) ? '0 : tx_tcnt + 1'b1;
      if (tx_bit_end && tx_state == TX_DATA) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + 1'b1;
      end
      if (tx_bit_end && tx_state == TX_STOP) tx_stop2 <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_param.sv
// tb_uart_param: randomized self-checking bench; dut0 is 8N1, dut1 is 8E2 with optional TX->RX loopback.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_param;
  localparam int CD   = 4;
  localparam int OS   = 16;
  localparam int BITC = CD * OS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       loop_en;
  logic       tx_valid_d [2];
  logic [7:0] tx_data_d  [2];
  logic       rx_drv     [2];
  logic       tx_o [2], ready_o [2], rxv_o [2], pe_o [2], fe_o [2], rxb_o [2], txb_o [2];
  logic [7:0] rxd_o [2];
  logic       brk_o [2];
  logic       rx1_in;

  assign rx1_in = loop_en ? tx_o[1] : rx_drv[1];
`ifndef UART_BREAK_DETECT_EN
  assign brk_o[0] = 1'b0;
  assign brk_o[1] = 1'b0;
`endif

  uart_param #(.CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_drv[0]), .tx(tx_o[0]),
    .tx_valid(tx_valid_d[0]), .tx_ready(ready_o[0]), .tx_data(tx_data_d[0]),
    .rx_valid(rxv_o[0]), .rx_data(rxd_o[0]), .rx_parity_err(pe_o[0]),
    .rx_frame_err(fe_o[0]), .rx_busy(rxb_o[0]), .tx_busy(txb_o[0])
`ifdef UART_BREAK_DETECT_EN
    , .rx_break(brk_o[0])
`endif
  );

  uart_param #(.CLK_DIV(CD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1_in), .tx(tx_o[1]),
    .tx_valid(tx_valid_d[1]), .tx_ready(ready_o[1]), .tx_data(tx_data_d[1]),
    .rx_valid(rxv_o[1]), .rx_data(rxd_o[1]), .rx_parity_err(pe_o[1]),
    .rx_frame_err(fe_o[1]), .rx_busy(rxb_o[1]), .tx_busy(txb_o[1])
`ifdef UART_BREAK_DETECT_EN
    , .rx_break(brk_o[1])
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int passed = 0;
  int total  = 0;

  always @(negedge clk) begin
    if (rxv_o[0]) q0.push_back({rxd_o[0], pe_o[0], fe_o[0], brk_o[0]});
    if (rxv_o[1]) q1.push_back({rxd_o[1], pe_o[1], fe_o[1], brk_o[1]});
  end

  // ---------------- reference model ----------------
  function automatic int par_of(input int s);
    return (s == 1) ? 1 : 0;
  endfunction

  function automatic int stops_of(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int flen(input int s);
    return 1 + 8 + ((par_of(s) != 0) ? 1 : 0) + stops_of(s);
  endfunction

  function automatic int ones(input logic [7:0] d);
    int c = 0;
    for (int i = 0; i < 8; i++) if (d[i]) c++;
    return c;
  endfunction

  function automatic logic exp_bit(input int s, input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (par_of(s) != 0 && k == 9) return (par_of(s) == 1) ? logic'(ones(d) % 2) : logic'(1 - ones(d) % 2);
    return 1'b1;
  endfunction

  function automatic logic exp_pe(input int s, input logic [7:0] d, input logic pb);
    int t;
    t = ones(d) + (pb ? 1 : 0);
    if (par_of(s) == 0) return 1'b0;
    if (par_of(s) == 1) return (t % 2) == 1;
    return (t % 2) == 0;
  endfunction

  function automatic logic exp_brk(input int s, input logic [7:0] d, input logic pb, input logic sb);
`ifdef UART_BREAK_DETECT_EN
    return (d == 8'h00) && (par_of(s) == 0 || !pb) && !sb;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic tx_send(input int s, input logic [7:0] d, input string nm);
    int L;
    int n;
    L = flen(s);
    n = 0;
    @(negedge clk);
    while (!ready_o[s] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ready_o[s] !== 1'b1) begin
      $display("FAIL %s_ready_wait got %b want 1", nm, ready_o[s]);
      return;
    end else passed++;
    tx_valid_d[s] = 1'b1;
    tx_data_d[s]  = d;
    for (int i = 1; i <= L * BITC + 1; i++) begin
      @(negedge clk);
      if (i == 1) begin
        tx_valid_d[s] = 1'b0;
        total++;
        if (tx_o[s] !== 1'b0 || ready_o[s] !== 1'b0)
          $display("FAIL %s_start got tx=%b ready=%b want tx=0 ready=0", nm, tx_o[s], ready_o[s]);
        else passed++;
      end
      if (i == 5) tx_data_d[s] = 8'($urandom);
      if (i == 7) tx_valid_d[s] = 1'b1;
      if (i == L * BITC - 3) tx_valid_d[s] = 1'b0;
      if (i % BITC == BITC / 2) begin
        total++;
        if (tx_o[s] !== exp_bit(s, d, i / BITC))
          $display("FAIL %s_bit%0d got %b want %b", nm, i / BITC, tx_o[s], exp_bit(s, d, i / BITC));
        else passed++;
      end
      if (i == L * BITC) begin
        total++;
        if (ready_o[s] !== 1'b0) $display("FAIL %s_ready_early got %b want 0", nm, ready_o[s]);
        else passed++;
      end
      if (i == L * BITC + 1) begin
        total++;
        if (ready_o[s] !== 1'b1 || tx_o[s] !== 1'b1)
          $display("FAIL %s_ready_end got ready=%b tx=%b want 1 1", nm, ready_o[s], tx_o[s]);
        else passed++;
      end
    end
  endtask

  task automatic rx_frame(input int s, input logic [7:0] d, input logic pb, input logic sb, input int idle_bits);
    rx_drv[s] = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv[s] = d[i];
      repeat (BITC) @(negedge clk);
    end
    if (par_of(s) != 0) begin
      rx_drv[s] = pb;
      repeat (BITC) @(negedge clk);
    end
    rx_drv[s] = sb;
    repeat (BITC) @(negedge clk);
    rx_drv[s] = 1'b1;
    repeat (idle_bits * BITC) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tx_valid_d[0] = 1'b1;
    tx_data_d[0]  = 8'h5A;
    repeat (4) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (tx_o[s] !== 1'b1) $display("FAIL reset_tx%0d got %b want 1", s, tx_o[s]); else passed++;
      total++;
      if (ready_o[s] !== 1'b1 || txb_o[s] !== 1'b0)
        $display("FAIL reset_ready%0d got %b/%b want 1/0", s, ready_o[s], txb_o[s]);
      else passed++;
      total++;
      if (rxv_o[s] !== 1'b0 || rxd_o[s] !== 8'h00)
        $display("FAIL reset_rxout%0d got v=%b d=%h want 0 00", s, rxv_o[s], rxd_o[s]);
      else passed++;
      total++;
      if (pe_o[s] !== 1'b0 || fe_o[s] !== 1'b0 || rxb_o[s] !== 1'b0 || brk_o[s] !== 1'b0)
        $display("FAIL reset_flags%0d got pe=%b fe=%b busy=%b brk=%b want 0", s, pe_o[s], fe_o[s], rxb_o[s], brk_o[s]);
      else passed++;
    end
    tx_valid_d[0] = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_8n1();
    tx_send(0, 8'hA5, "tx_a5");
    for (int k = 0; k < 3; k++) tx_send(0, 8'($urandom), "tx_rand");
  endtask

  task automatic test_loopback_even();
    logic [7:0] d;
    rec_t r;
    loop_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? 8'h3C : 8'($urandom);
      q1.delete();
      tx_send(1, d, "loop_tx");
      repeat (10) @(negedge clk);
      total++;
      if (q1.size() != 1) begin
        $display("FAIL loop_count got %0d want 1", q1.size());
        continue;
      end else passed++;
      r = q1.pop_front();
      total++;
      if (r.d !== d || r.pe !== 1'b0 || r.fe !== 1'b0)
        $display("FAIL loop_rx got d=%h pe=%b fe=%b want d=%h pe=0 fe=0", r.d, r.pe, r.fe, d);
      else passed++;
    end
    loop_en = 1'b0;
  endtask

  task automatic test_parity_err();
    logic [7:0] d;
    logic pb;
    rec_t r;
    for (int k = 0; k < 5; k++) begin
      d  = (k == 0) ? 8'h3C : 8'($urandom);
      pb = (k == 0) ? 1'b1 : 1'($urandom);
      q1.delete();
      rx_frame(1, d, pb, 1'b1, 2);
      total++;
      if (q1.size() != 1) begin
        $display("FAIL par_count got %0d want 1", q1.size());
        continue;
      end else passed++;
      r = q1.pop_front();
      total++;
      if (r.d !== d || r.pe !== exp_pe(1, d, pb) || r.fe !== 1'b0)
        $display("FAIL par_rx got d=%h pe=%b fe=%b want d=%h pe=%b fe=0", r.d, r.pe, r.fe, d, exp_pe(1, d, pb));
      else passed++;
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    logic sb;
    rec_t r;
    for (int k = 0; k < 6; k++) begin
      d  = (k == 0) ? 8'h55 : (k == 1) ? 8'h12 : 8'($urandom);
      sb = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : 1'($urandom);
      q0.delete();
      rx_frame(0, d, 1'b0, sb, 2);
      total++;
      if (q0.size() != 1) begin
        $display("FAIL frm_count got %0d want 1", q0.size());
        continue;
      end else passed++;
      r = q0.pop_front();
      total++;
      if (r.d !== d || r.pe !== 1'b0 || r.fe !== !sb || r.brk !== exp_brk(0, d, 1'b0, sb))
        $display("FAIL frm_rx got d=%h pe=%b fe=%b brk=%b want d=%h pe=0 fe=%b brk=%b",
                 r.d, r.pe, r.fe, r.brk, d, !sb, exp_brk(0, d, 1'b0, sb));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [3];
    rec_t r;
    q0.delete();
    for (int k = 0; k < 3; k++) begin
      d[k] = 8'($urandom);
      rx_frame(0, d[k], 1'b0, 1'b1, (k == 2) ? 2 : 0);
    end
    total++;
    if (q0.size() != 3) $display("FAIL b2b_count got %0d want 3", q0.size());
    else passed++;
    for (int k = 0; k < 3 && q0.size() > 0; k++) begin
      r = q0.pop_front();
      total++;
      if (r.d !== d[k] || r.fe !== 1'b0 || r.pe !== 1'b0)
        $display("FAIL b2b_rx%0d got d=%h fe=%b pe=%b want d=%h fe=0 pe=0", k, r.d, r.fe, r.pe, d[k]);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    bit saw_busy;
    int n;
    saw_busy = 1'b0;
    n = 0;
    q0.delete();
    rx_drv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv[0] = 1'b1;
    while (n < 60 && !(saw_busy && !rxb_o[0])) begin
      @(negedge clk);
      if (rxb_o[0]) saw_busy = 1'b1;
      n++;
    end
    total++;
    if (!saw_busy) $display("FAIL glitch_busy got 0 want 1"); else passed++;
    total++;
    if (rxb_o[0] !== 1'b0) $display("FAIL glitch_idle got busy=%b after %0d clks want 0", rxb_o[0], n);
    else passed++;
    repeat (100) @(negedge clk);
    total++;
    if (q0.size() != 0) $display("FAIL glitch_valid got %0d frames want 0", q0.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    q0.delete();
    q1.delete();
    tx_valid_d[0] = 1'b1;
    tx_data_d[0]  = 8'($urandom);
    rx_drv[1]     = 1'b0;
    @(negedge clk);
    tx_valid_d[0] = 1'b0;
    repeat (200) @(negedge clk);
    total++;
    if (txb_o[0] !== 1'b1 || rxb_o[1] !== 1'b1)
      $display("FAIL mid_active got txbusy=%b rxbusy=%b want 1 1", txb_o[0], rxb_o[1]);
    else passed++;
    rst_n     = 1'b0;
    rx_drv[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (tx_o[0] !== 1'b1 || ready_o[0] !== 1'b1 || rxb_o[1] !== 1'b0)
      $display("FAIL mid_reset got tx=%b ready=%b rxbusy=%b want 1 1 0", tx_o[0], ready_o[0], rxb_o[1]);
    else passed++;
    repeat (1000) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0 || ready_o[0] !== 1'b1)
      $display("FAIL mid_after got frames=%0d/%0d ready=%b want 0/0 1", q0.size(), q1.size(), ready_o[0]);
    else passed++;
  endtask

`ifdef UART_BREAK_DETECT_EN
  task automatic test_break();
    rec_t r;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) q0.delete(); else q1.delete();
      rx_frame(s, 8'h00, 1'b0, 1'b0, 3);
      total++;
      if ((s == 0 ? q0.size() : q1.size()) != 1) begin
        $display("FAIL brk_count%0d got %0d want 1", s, (s == 0 ? q0.size() : q1.size()));
        continue;
      end else passed++;
      r = (s == 0) ? q0.pop_front() : q1.pop_front();
      total++;
      if (r.brk !== 1'b1 || r.fe !== 1'b1 || r.d !== 8'h00)
        $display("FAIL brk_rx%0d got brk=%b fe=%b d=%h want 1 1 00", s, r.brk, r.fe, r.d);
      else passed++;
      total++;
      if (rxb_o[s] !== 1'b0) $display("FAIL brk_idle%0d got busy=%b want 0", s, rxb_o[s]); else passed++;
    end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    loop_en = 1'b0;
    rst_n   = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tx_valid_d[s] = 1'b0;
      tx_data_d[s]  = 8'h00;
      rx_drv[s]     = 1'b1;
    end
    @(negedge clk);
    test_reset();
    test_tx_8n1();
    test_loopback_even();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
`ifdef UART_BREAK_DETECT_EN
    test_break();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
